unidade_controle: RTL and testbench

Control unit for the 16-bit simple processor. Fetches a 9-bit instruction from the data input and sequences it over time steps T0–T3. Drives the bus-select lines of the bus multiplexer (`controlReg`, `Gout`, `Din`) and the load enables of the bus receivers (register file, A, G, IR). It is the initiator of every bus transfer: it decides which source drives the bus and which destination captures it.

---
 rtl/unidade_controle.sv | 118 +++++++++++
 tb/tb_unidade_controle.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Control unit for the 16-bit simple processor: fetches a 9-bit IR and sequences T0..T3.
// Optional feature macro: CONTROLE_MVNZ_EN (opcode 100 = mvnz Rx,Ry gated by GnZ).
module unidade_controle (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Run,
  input  logic [15:0] Dado,
  input  logic        GnZ,
  output logic [7:0]  controlReg,
  output logic        Gout,
  output logic        Din,
  output logic [7:0]  Rin,
  output logic        Ain,
  output logic        Gin,
  output logic        AddSub,
  output logic        IRin,
  output logic        Done
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} tstep_e;

  tstep_e      tstep_q, tstep_d;
  logic [8:0]  ir_q, ir_d;
  logic [2:0]  opcode, rx, ry;

  assign opcode = ir_q[8:6];
  assign rx     = ir_q[5:3];
  assign ry     = ir_q[2:0];

  // Only the low nine bits of Dado form an instruction word.
  logic unused_dado_hi;
  assign unused_dado_hi = ^Dado[15:9];

`ifndef CONTROLE_MVNZ_EN
  logic unused_gnz;
  assign unused_gnz = GnZ;
`endif

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

  always_comb begin
    tstep_d    = tstep_q;
    controlReg = 8'h00;
    Gout       = 1'b0;
    Din        = 1'b0;
    Rin        = 8'h00;
    Ain        = 1'b0;
    Gin        = 1'b0;
    AddSub     = 1'b0;
    IRin       = 1'b0;
    Done       = 1'b0;
    case (tstep_q)
      T0: begin
        IRin = Run;
        if (Run) tstep_d = T1;
      end
      T1: begin
        tstep_d = T0;
        case (opcode)
          3'b000: begin
            controlReg = onehot(ry);
            Rin        = onehot(rx);
            Done       = 1'b1;
          end
          3'b001: begin
            Din  = 1'b1;
            Rin  = onehot(rx);
            Done = 1'b1;
          end
          3'b010, 3'b011: begin
            controlReg = onehot(rx);
            Ain        = 1'b1;
            tstep_d    = T2;
          end
`ifdef CONTROLE_MVNZ_EN
          3'b100: begin
            Done = 1'b1;
            if (GnZ) begin
              controlReg = onehot(ry);
              Rin        = onehot(rx);
            end
          end
`endif
          default: Done = 1'b1;
        endcase
      end
      T2: begin
        // IR[6] distinguishes sub (011) from add (010).
        controlReg = onehot(ry);
        Gin        = 1'b1;
        AddSub     = ir_q[6];
        tstep_d    = T3;
      end
      T3: begin
        Gout    = 1'b1;
        Rin     = onehot(rx);
        Done    = 1'b1;
        tstep_d = T0;
      end
      default: tstep_d = T0;
    endcase
  end

  assign ir_d = IRin ? Dado[8:0] : ir_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tstep_q <= T0;
      ir_q    <= 9'b0;
    end else begin
      tstep_q <= tstep_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: stimulus pushes expected output vectors, monitor pops and compares.
module tb_unidade_controle;

  logic        Clock;
  logic        Reset;
  logic        Run;
  logic [15:0] Dado;
  logic        GnZ;
  logic [7:0]  controlReg;
  logic        Gout;
  logic        Din;
  logic [7:0]  Rin;
  logic        Ain;
  logic        Gin;
  logic        AddSub;
  logic        IRin;
  logic        Done;

  unidade_controle dut (
    .Clock(Clock), .Reset(Reset), .Run(Run), .Dado(Dado), .GnZ(GnZ),
    .controlReg(controlReg), .Gout(Gout), .Din(Din), .Rin(Rin),
    .Ain(Ain), .Gin(Gin), .AddSub(AddSub), .IRin(IRin), .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [22:0] exp;
    string       name;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  localparam logic [22:0] ZERO = 23'd0;

  function automatic logic [22:0] E(input logic [7:0] cr, input logic go, input logic di,
                                    input logic [7:0] rn, input logic a, input logic gi,
                                    input logic as, input logic ir, input logic dn);
    return {cr, go, di, rn, a, gi, as, ir, dn};
  endfunction

  // Monitor: compares the DUT outputs of each cycle that has a pending expectation.
  always @(negedge Clock) begin
    if (sb_q.size() > 0) begin
      sb_entry_t e;
      logic [22:0] act;
      e   = sb_q.pop_front();
      act = {controlReg, Gout, Din, Rin, Ain, Gin, AddSub, IRin, Done};
      n_cmp++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got cr=%h go=%b din=%b rin=%h ain=%b gin=%b as=%b irin=%b done=%b, expected vector %h (got %h)",
                 e.name, act[22:15], act[14], act[13], act[12:5], act[4], act[3], act[2], act[1], act[0],
                 e.exp, act);
      end
    end
  end

  task automatic cyc(input logic rst, input logic run, input logic [15:0] d, input logic g,
                     input logic [22:0] exp, input string nm);
    sb_entry_t e;
    @(posedge Clock);
    #1;
    Reset = rst;
    Run   = run;
    Dado  = d;
    GnZ   = g;
    e.exp  = exp;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    Dado  = 16'h0000;
    GnZ   = 1'b0;

    cyc(1, 0, 16'h0000, 0, ZERO, "reset_state");
    cyc(0, 0, 16'h0000, 0, ZERO, "idle_t0");

    // mvi R0,#5
    cyc(0, 1, 16'h0040, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "mvi_t0");
    cyc(0, 0, 16'h0005, 0, E(8'h00,0,1,8'h01,0,0,0,0,1), "mvi_t1");
    cyc(0, 0, 16'h0000, 0, ZERO, "mvi_after");

    // mv R7,R2
    cyc(0, 1, 16'h003A, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "mv_t0");
    cyc(0, 0, 16'h0000, 0, E(8'h04,0,0,8'h80,0,0,0,0,1), "mv_t1");
    cyc(0, 0, 16'h0000, 0, ZERO, "mv_after");

    // sub R1,R3 with Run high in T1 (must be ignored)
    cyc(0, 1, 16'h00CB, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "sub_t0");
    cyc(0, 1, 16'h00CB, 0, E(8'h02,0,0,8'h00,1,0,0,0,0), "sub_t1");
    cyc(0, 0, 16'h0000, 0, E(8'h08,0,0,8'h00,0,1,1,0,0), "sub_t2");
    cyc(0, 0, 16'h0000, 0, E(8'h00,1,0,8'h02,0,0,0,0,1), "sub_t3");
    cyc(0, 0, 16'h0000, 0, ZERO, "sub_after");

    // Back-to-back: mv R1,R0 then add R2,R2 with Run held high
    cyc(0, 1, 16'h0008, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "b2b_mv_t0");
    cyc(0, 1, 16'h0092, 0, E(8'h01,0,0,8'h02,0,0,0,0,1), "b2b_mv_t1");
    cyc(0, 1, 16'h0092, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "b2b_add_t0");
    cyc(0, 1, 16'h0000, 0, E(8'h04,0,0,8'h00,1,0,0,0,0), "b2b_add_t1");
    cyc(0, 1, 16'h0000, 0, E(8'h04,0,0,8'h00,0,1,0,0,0), "b2b_add_t2");
    cyc(0, 0, 16'h0000, 0, E(8'h00,1,0,8'h04,0,0,0,0,1), "b2b_add_t3");
    cyc(0, 0, 16'h0000, 0, ZERO, "b2b_after");

    // Opcode 100 (mvnz R4,R5) with GnZ low, then high
    cyc(0, 1, 16'h0125, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "op100_a_t0");
    cyc(0, 0, 16'h0000, 0, E(8'h00,0,0,8'h00,0,0,0,0,1), "op100_gnz0_t1");
    cyc(0, 1, 16'h0125, 1, E(8'h00,0,0,8'h00,0,0,0,1,0), "op100_b_t0");
`ifdef CONTROLE_MVNZ_EN
    cyc(0, 0, 16'h0000, 1, E(8'h20,0,0,8'h10,0,0,0,0,1), "mvnz_gnz1_t1");
`else
    cyc(0, 0, 16'h0000, 1, E(8'h00,0,0,8'h00,0,0,0,0,1), "op100_gnz1_t1");
`endif

    // Undefined opcode 111
    cyc(0, 1, 16'hFFFF, 1, E(8'h00,0,0,8'h00,0,0,0,1,0), "undef_t0");
    cyc(0, 0, 16'h0000, 0, E(8'h00,0,0,8'h00,0,0,0,0,1), "undef_t1");

    // add R3,R1 interrupted by Reset in the middle of T2
    cyc(0, 1, 16'h0099, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "rst_add_t0");
    cyc(0, 0, 16'h0000, 0, E(8'h08,0,0,8'h00,1,0,0,0,0), "rst_add_t1");
    cyc(0, 0, 16'h0000, 0, E(8'h02,0,0,8'h00,0,1,0,0,0), "rst_add_t2");
    @(negedge Clock);
    #2 Reset = 1'b1;
    cyc(1, 0, 16'h0000, 0, ZERO, "rst_mid_t2");
    cyc(0, 0, 16'h0000, 0, ZERO, "rst_release_t0");
    cyc(0, 1, 16'h0000, 0, E(8'h00,0,0,8'h00,0,0,0,1,0), "rst_next_t0");
    cyc(0, 0, 16'h0000, 0, E(8'h01,0,0,8'h01,0,0,0,0,1), "rst_next_mv_t1");

    for (int i = 0; i < 20 && sb_q.size() > 0; i++) @(posedge Clock);
    if (sb_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
